vga_scan_gen: RTL

- Parametrised VGA scan generator for the framebuffer display path.
- Divides the system clock down to the pixel rate and runs horizontal/vertical counters with configurable timing and sync polarity.
- Produces a scaled framebuffer read address and accepts pixel data back after a fixed memory latency.
- Aligns RGB, sync and line/frame pulses so the memory fetch latency is invisible at the pins.

---
 rtl/vga_scan_gen.sv | 111 +++++++++++
 1 files changed

// File: rtl/vga_scan_gen.sv
// vga_scan_gen: VGA timing generator with pixel prescaler, scaled framebuffer
// address output and a latency-matched output stage.
// Ports:
//   clk, reset_n          system clock, asynchronous active-low reset
//   fb_addr, fb_rd        framebuffer read address {y, x} and active-area strobe
//   pix_data              framebuffer read data, sampled on the load edge
//   rgb, hsync, vsync     registered pixel and sync outputs
//   line_start, frame_start  one-clk pulses on the first pixel of a line/frame
//   hpos, vpos            current horizontal/vertical counters
module vga_scan_gen #(
  parameter int CLK_DIV       = 4,
  parameter int H_ACTIVE      = 640,
  parameter int H_FP          = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BP          = 48,
  parameter int V_ACTIVE      = 400,
  parameter int V_FP          = 11,
  parameter int V_SYNC        = 2,
  parameter int V_BP          = 32,
  parameter bit HSYNC_POL     = 1'b0,
  parameter bit VSYNC_POL     = 1'b0,
  parameter int SCALE_LOG2    = 2,
  parameter int ADDR_X_BITS   = 8,
  parameter int ADDR_Y_BITS   = 7,
  parameter int PIXEL_BITS    = 8,
  parameter int FETCH_LATENCY = 1
) (
  input  logic                               clk,
  input  logic                               reset_n,
  output logic [ADDR_Y_BITS+ADDR_X_BITS-1:0] fb_addr,
  output logic                               fb_rd,
  input  logic [PIXEL_BITS-1:0]              pix_data,
  output logic [PIXEL_BITS-1:0]              rgb,
  output logic                               hsync,
  output logic                               vsync,
  output logic                               line_start,
  output logic                               frame_start,
  output logic [15:0]                        hpos,
  output logic [15:0]                        vpos
);
  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] P_LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] P_LOAD = PW'(FETCH_LATENCY);
  localparam logic [15:0] H_TOT = 16'(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam logic [15:0] H_ACT = 16'(H_ACTIVE);
  localparam logic [15:0] H_SS  = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] H_SE  = 16'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [15:0] V_TOT = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam logic [15:0] V_ACT = 16'(V_ACTIVE);
  localparam logic [15:0] V_SS  = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] V_SE  = 16'(V_ACTIVE + V_FP + V_SYNC);

  logic [PW-1:0]         presc_q, presc_d;
  logic [15:0]           hpos_q, hpos_d, vpos_q, vpos_d;
  logic [PIXEL_BITS-1:0] rgb_q, rgb_d;
  logic                  hsync_q, hsync_d, vsync_q, vsync_d;
  logic                  ls_q, ls_d, fs_q, fs_d;
  logic                  adv, load, line_end, active;

  // Counters advance on the last clk of a pixel; the output stage loads
  // FETCH_LATENCY clks into the next pixel, once the memory data is valid,
  // so every output trails the counters by the same FETCH_LATENCY+1 clks.
  always_comb begin
    adv      = presc_q == P_LAST;
    load     = presc_q == P_LOAD;
    line_end = hpos_q == H_TOT - 16'd1;
    active   = hpos_q < H_ACT && vpos_q < V_ACT;
    presc_d  = adv ? '0 : presc_q + PW'(1);
    hpos_d   = adv ? (line_end ? '0 : hpos_q + 16'd1) : hpos_q;
    vpos_d   = (adv && line_end) ? (vpos_q == V_TOT - 16'd1 ? '0 : vpos_q + 16'd1) : vpos_q;
    rgb_d    = load ? (active ? pix_data : '0) : rgb_q;
    hsync_d  = load ? ((hpos_q >= H_SS && hpos_q < H_SE) ? HSYNC_POL : ~HSYNC_POL) : hsync_q;
    vsync_d  = load ? ((vpos_q >= V_SS && vpos_q < V_SE) ? VSYNC_POL : ~VSYNC_POL) : vsync_q;
    ls_d     = load && hpos_q == '0;
    fs_d     = load && hpos_q == '0 && vpos_q == '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      hpos_q  <= '0;
      vpos_q  <= '0;
      rgb_q   <= '0;
      hsync_q <= ~HSYNC_POL;
      vsync_q <= ~VSYNC_POL;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      presc_q <= presc_d;
      hpos_q  <= hpos_d;
      vpos_q  <= vpos_d;
      rgb_q   <= rgb_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
    end
  end

  // Counters sit at 0,0 (an active pixel) during reset; gating with reset_n
  // keeps the read strobe quiet until the scan actually runs.
  assign fb_addr     = {ADDR_Y_BITS'(vpos_q >> SCALE_LOG2), ADDR_X_BITS'(hpos_q >> SCALE_LOG2)};
  assign fb_rd       = active & reset_n;
  assign rgb         = rgb_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign hpos        = hpos_q;
  assign vpos        = vpos_q;
endmodule
